// File: rtl/manch_rx_ctrl_if.sv
// Bit-stream input and byte handshake output of the Manchester frame receiver.
interface manch_rx_ctrl_if;
  logic       bit_valid;
  logic       bit_data;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output bit_valid, bit_data, byte_ready,
    input  byte_data, byte_valid
  );

  modport slave (
    input  bit_valid, bit_data, byte_ready,
    output byte_data, byte_valid
  );
endinterface

// File: rtl/manch_rx_ctrl.sv
// Manchester frame receiver: preamble/sync hunt, byte assembly, gap timeout.
// Optional CRC-8 residue check enabled with MANCH_RX_CRC8_EN.
module manch_rx_ctrl #(
  parameter int         CLK_FREQ      = 18_750_000,
  parameter int         BAUDRATE      = 230400,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hD5,
  parameter int         MAX_BYTES     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  manch_rx_ctrl_if.slave bus,
  output logic frame_start,
  output logic frame_end,
  output logic frame_err,
  output logic busy
);
  localparam int TIMEOUT = 4 * CLK_FREQ / BAUDRATE;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam int BW = $clog2(MAX_BYTES + 2);

  typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, DATA} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre_cnt, pre_n, pre_inc;
  logic            prev_bit, prev_n;
  logic [7:0]      sh, sh_n, shift;
  logic [3:0]      sync_cnt, sync_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [BW-1:0]   byte_cnt, byte_n;
  logic [TW-1:0]   gap, gap_n;
  logic [7:0]      bd_q, bd_n;
  logic            bv_q, bv_n;
  logic            start_n, end_n, err_n;
  logic            tmo, crc_ok;

`ifdef MANCH_RX_CRC8_EN
  logic [7:0] crc, crc_n, crc_step;
  assign crc_step = {crc[6:0], 1'b0} ^
                    ((crc[7] ^ bus.bit_data) ? 8'h07 : 8'h00);
  assign crc_ok = (crc == 8'h00);
`else
  assign crc_ok = 1'b1;
`endif

  assign shift = {sh[6:0], bus.bit_data};
  assign pre_inc = pre_cnt + PW'(1);
  assign tmo = (gap == TW'(TIMEOUT));
  assign busy = (state != IDLE);
  assign bus.byte_data = bd_q;
  assign bus.byte_valid = bv_q;

  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    prev_n  = prev_bit;
    sh_n    = sh;
    sync_n  = sync_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    bd_n    = bd_q;
    bv_n    = bv_q & ~bus.byte_ready;
    start_n = 1'b0;
    end_n   = 1'b0;
    err_n   = 1'b0;
`ifdef MANCH_RX_CRC8_EN
    crc_n   = crc;
`endif
    if (bus.bit_valid || state == IDLE)
      gap_n = '0;
    else if (tmo)
      gap_n = gap;
    else
      gap_n = gap + TW'(1);

    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.bit_valid) begin
            state_n = PREAMBLE;
            pre_n   = PW'(1);
            prev_n  = bus.bit_data;
          end
        end
        PREAMBLE: begin
          if (bus.bit_valid) begin
            prev_n = bus.bit_data;
            if (bus.bit_data != prev_bit) begin
              pre_n = pre_inc;
              if (pre_inc == PW'(PREAMBLE_BITS)) begin
                state_n = SYNC;
                sh_n    = '0;
                sync_n  = '0;
              end
            end else begin
              pre_n = PW'(1);
            end
          end else if (tmo) begin
            state_n = IDLE;
          end
        end
        SYNC: begin
          if (bus.bit_valid) begin
            sh_n = shift;
            if (shift == SYNC_BYTE) begin
              state_n = DATA;
              start_n = 1'b1;
              sh_n    = '0;
              bit_n   = '0;
              byte_n  = '0;
`ifdef MANCH_RX_CRC8_EN
              crc_n   = '0;
`endif
            end else if (sync_cnt == 4'd15) begin
              state_n = IDLE;
              err_n   = 1'b1;
            end else begin
              sync_n = sync_cnt + 4'd1;
            end
          end else if (tmo) begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (bus.bit_valid) begin
            sh_n  = shift;
            bit_n = bit_cnt + 3'd1;
`ifdef MANCH_RX_CRC8_EN
            crc_n = crc_step;
`endif
            if (bit_cnt == 3'd7) begin
              byte_n = byte_cnt + BW'(1);
              // overflow and overrun both drop the fresh byte
              if (byte_cnt == BW'(MAX_BYTES) ||
                  (bv_q && !bus.byte_ready)) begin
                state_n = IDLE;
                err_n   = 1'b1;
              end else begin
                bd_n = shift;
                bv_n = 1'b1;
              end
            end
          end else if (tmo) begin
            state_n = IDLE;
            if (bit_cnt == 3'd0 && byte_cnt != '0 && crc_ok)
              end_n = 1'b1;
            else
              err_n = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      prev_bit    <= 1'b0;
      sh          <= '0;
      sync_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      gap         <= '0;
      bd_q        <= '0;
      bv_q        <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
`ifdef MANCH_RX_CRC8_EN
      crc         <= '0;
`endif
    end else begin
      state       <= state_n;
      pre_cnt     <= pre_n;
      prev_bit    <= prev_n;
      sh          <= sh_n;
      sync_cnt    <= sync_n;
      bit_cnt     <= bit_n;
      byte_cnt    <= byte_n;
      gap         <= gap_n;
      bd_q        <= bd_n;
      bv_q        <= bv_n;
      frame_start <= start_n;
      frame_end   <= end_n;
      frame_err   <= err_n;
`ifdef MANCH_RX_CRC8_EN
      crc         <= crc_n;
`endif
    end
  end
endmodule

// File: doc/manch_rx_ctrl.md
MANCH_RX_CTRL -- requirements
Module: manch_rx_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 18_750_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 230400, Manchester half-bit rate (bit period = 2*CLK_FREQ/BAUDRATE clocks).
REQ-003 Parameter PREAMBLE_BITS, default 8, number of consecutive alternating bits required before sync search.
REQ-004 Parameter SYNC_BYTE, default 8'hD5, start-of-frame delimiter.
REQ-005 Parameter MAX_BYTES, default 16, maximum payload bytes per frame, including the CRC byte when present.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 enable  in  1  receiver enable; low forces IDLE.
REQ-009 bit_valid  in  1  one-cycle strobe from the Manchester decoder per decoded bit.
REQ-010 bit_data  in  1  decoded bit value, qualified by bit_valid.
REQ-011 byte_data  out  8  assembled payload byte.
REQ-012 byte_valid  out  1  byte_data valid; held until accepted.
REQ-013 byte_ready  in  1  consumer accept; transfer occurs when byte_valid && byte_ready.
REQ-014 frame_start  out  1  one-cycle pulse on SYNC_BYTE match.
REQ-015 frame_end  out  1  one-cycle pulse on normal frame termination.
REQ-016 frame_err  out  1  one-cycle pulse on any frame error.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, PREAMBLE, SYNC, DATA; state changes occur only on clk rising edge.
REQ-019 IDLE -> PREAMBLE on first bit_valid while enable=1; preamble count starts at 1.
REQ-020 PREAMBLE: count increments when bit_data differs from the previous bit; an equal bit resets the count to 1; count = PREAMBLE_BITS -> SYNC.
REQ-021 SYNC: 8-bit shift register, MSB-first; match with SYNC_BYTE -> DATA and pulse frame_start; 16 bits without a match -> frame_err pulse and IDLE.
REQ-022 DATA: bits shifted MSB-first; the 8th bit loads byte_data and sets byte_valid on the next cycle (latency 1 clock after the 8th bit_valid).
REQ-023 Byte completion while byte_valid is still high: new byte dropped, existing byte kept, frame_err pulse, -> IDLE.
REQ-024 Bit-gap timer: counts clocks since the last bit_valid and reloads on each bit_valid; timeout = 4*CLK_FREQ/BAUDRATE clocks; width $clog2(timeout)+1.
REQ-025 Timeout in DATA at a byte boundary with at least one byte received -> frame_end pulse and IDLE; timeout mid-byte or with zero bytes -> frame_err pulse and IDLE.
REQ-026 Timeout in PREAMBLE or SYNC -> IDLE silently, no pulse.
REQ-027 Byte count exceeding MAX_BYTES -> frame_err pulse and IDLE; the excess byte is not presented.
REQ-028 bit_valid coinciding with timeout expiry: the bit takes priority and the timer reloads.
REQ-029 byte_ready coinciding with a new byte load: the old byte transfers and the new byte loads in the same cycle; no overrun.
REQ-030 enable low: -> IDLE on the next clock; partial byte discarded; no pulse; a pending byte_valid remains until accepted.
REQ-031 frame_start, frame_end and frame_err are mutually exclusive in any cycle.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE; byte_data=0; byte_valid, frame_start, frame_end, frame_err and busy =0; all counters and shift registers =0.
REQ-033 Reset mid-frame abandons the frame without a pulse; the pending byte is lost.

Configuration
REQ-034 Macro MANCH_RX_CRC8_EN defined: CRC-8 (poly 0x07, init 0x00) runs over all DATA bytes including the final CRC byte; at normal termination a nonzero residue pulses frame_err instead of frame_end; the CRC byte is still presented on byte_data.
REQ-035 Macro undefined: no CRC logic is present and termination follows REQ-025 alone.

Verification
REQ-036 Preamble of 8 alternating bits, then D5, 3E, 41, then silence -> frame_start pulse, bytes 3E and 41 with byte_ready=1, one frame_end pulse, busy=0.
REQ-037 Preamble broken by a repeated bit at bit 5, then 8 clean alternating bits and D5 -> exactly one frame_start after the clean preamble.
REQ-038 Valid frame with byte_ready=0 held through 2 bytes -> first byte retained, frame_err at 2nd byte completion, state IDLE.
REQ-039 Frame with 17 payload bytes (MAX_BYTES=16) -> 16 bytes delivered, frame_err at the 17th, no frame_end.
REQ-040 Timeout after 4 bits of a byte -> frame_err; rst_n=0 mid-frame -> all outputs 0 the next cycle.
REQ-041 MANCH_RX_CRC8_EN defined, payload 01 followed by its CRC-8 byte 07 -> frame_end; payload 01 followed by 08 -> frame_err.
